// File: rtl/sym_player_if.sv
`default_nettype none
// ============================================================================
//  Module      : sym_player_if
//  Description : Programming / control / status bundle for sym_player.
//                master : the controller (bench, CPU, sequencer) that writes
//                         entries and starts/stops playback.
//                slave  : the sym_player itself.
//  Signals     : wr_en/wr_sym/wr_hold  append one (symbol, hold) entry
//                flush                 empty the entry list
//                start/loop/stop       playback control
//                sym/busy/done         playback status
//                full/count            list occupancy
//  Revision    : 1.0 - initial release
// ============================================================================
interface sym_player_if #(
    parameter int DEPTH  = 8,
    parameter int HOLD_W = 4
) ();
    logic                     wr_en;
    logic [1:0]               wr_sym;
    logic [HOLD_W-1:0]        wr_hold;
    logic                     flush;
    logic                     start;
    logic                     loop;
    logic                     stop;
    logic [1:0]               sym;
    logic                     busy;
    logic                     done;
    logic                     full;
    logic [$clog2(DEPTH):0]   count;

    modport master (
        output wr_en, wr_sym, wr_hold, flush, start, loop, stop,
        input  sym, busy, done, full, count
    );

    modport slave (
        input  wr_en, wr_sym, wr_hold, flush, start, loop, stop,
        output sym, busy, done, full, count
    );
endinterface
`default_nettype wire

// File: rtl/sym_player.sv
`default_nettype none
// ============================================================================
//  Module      : sym_player
//  Description : Programmable 2-bit symbol stimulus transmitter. Stores up to
//                DEPTH (symbol, hold) entries and, on start, drives each
//                symbol for hold+1 cycles, once or looped. The last driven
//                symbol is held while idle.
//  Ports       : clk  - rising-edge clock
//                clr  - asynchronous active-low reset
//                bus  - sym_player_if.slave (write, control and status)
//  Revision    : 1.0 - initial release
// ============================================================================
module sym_player #(
    parameter int DEPTH  = 8,
    parameter int HOLD_W = 4
) (
    input  wire logic     clk,
    input  wire logic     clr,
    sym_player_if.slave   bus
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int CNT_W = IDX_W + 1;

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_PLAY = 1'b1
    } state_t;

    // Entry storage (no reset: contents are don't-care until written)
    logic [1:0]        sym_mem_q  [DEPTH];
    logic [HOLD_W-1:0] hold_mem_q [DEPTH];

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  count_q,  count_d;
    logic [IDX_W-1:0]  idx_q,    idx_d;
    logic [HOLD_W-1:0] hold_q,   hold_d;
    logic              loop_q,   loop_d;
    logic [1:0]        sym_q,    sym_d;
    logic              done_q,   done_d;

    logic              w_idle;
    logic              w_full;
    logic              w_wr_accept;
    logic              w_last;
    logic [IDX_W-1:0]  w_idx_next;

    assign w_idle      = (state_q == S_IDLE);
    assign w_full      = (count_q == CNT_W'(DEPTH));
    // flush beats a simultaneous write
    assign w_wr_accept = w_idle && bus.wr_en && !w_full && !bus.flush;
    assign w_last      = ({1'b0, idx_q} == (count_q - CNT_W'(1)));
    assign w_idx_next  = idx_q + IDX_W'(1);

    // Entry array write port; count doubles as the write pointer
    always_ff @(posedge clk) begin
        if (w_wr_accept) begin
            sym_mem_q[count_q[IDX_W-1:0]]  <= bus.wr_sym;
            hold_mem_q[count_q[IDX_W-1:0]] <= bus.wr_hold;
        end
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state_q <= S_IDLE;
            count_q <= '0;
            idx_q   <= '0;
            hold_q  <= '0;
            loop_q  <= 1'b0;
            sym_q   <= 2'b00;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            idx_q   <= idx_d;
            hold_q  <= hold_d;
            loop_q  <= loop_d;
            sym_q   <= sym_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        idx_d   = idx_q;
        hold_d  = hold_q;
        loop_d  = loop_q;
        sym_d   = sym_q;
        done_d  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (bus.flush) begin
                    count_d = '0;
                end else if (w_wr_accept) begin
                    count_d = count_q + CNT_W'(1);
                end
                // A flush in the same cycle empties the list, so start
                // must not launch playback from stale entries.
                if (bus.start && !bus.flush && (count_q != '0)) begin
                    state_d = S_PLAY;
                    idx_d   = '0;
                    hold_d  = hold_mem_q[0];
                    sym_d   = sym_mem_q[0];
                    loop_d  = bus.loop;
                end
            end

            S_PLAY: begin
                // sym_q already shows entry[idx]; the next entry's symbol is
                // loaded together with its hold so there is no gap cycle.
                if (bus.stop) begin
                    state_d = S_IDLE;
                end else if (hold_q != '0) begin
                    hold_d = hold_q - HOLD_W'(1);
                end else if (!w_last) begin
                    idx_d  = w_idx_next;
                    hold_d = hold_mem_q[w_idx_next];
                    sym_d  = sym_mem_q[w_idx_next];
                end else if (loop_q) begin
                    idx_d  = '0;
                    hold_d = hold_mem_q[0];
                    sym_d  = sym_mem_q[0];
                end else begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign bus.sym   = sym_q;
    assign bus.busy  = (state_q == S_PLAY);
    assign bus.done  = done_q;
    assign bus.count = count_q;
    assign bus.full  = w_full;

endmodule
`default_nettype wire

// File: doc/sym_player.md
# sym_player

Programmable stimulus transmitter for the 2-bit symbol input of the lab FSM blocks. It stores a short list of (symbol, hold) entries and, on a start pulse, drives each symbol onto `sym` for a programmed number of clock cycles. It plays the list once or loops it, then holds the last symbol. It sits in front of any FSM with a 2-bit `in` port and replaces hand-written delay sequences in benches and on-board demos.

## Interface
- `DEPTH`, default 8: number of entries; power of two, 2..16.
- `HOLD_W`, default 4: width of the hold field. An entry is driven for hold+1 cycles.
- `clk` input 1: single clock, rising edge.
- `clr` input 1: reset, asynchronous, active-low.
- `wr_en` input 1: append one entry at the write pointer.
- `wr_sym` input 2: symbol of the appended entry.
- `wr_hold` input HOLD_W: hold value of the appended entry (cycles-1).
- `flush` input 1: empty the entry list.
- `start` input 1: begin playback.
- `loop` input 1: repeat mode; sampled together with `start`.
- `stop` input 1: abort playback.
- `sym` output 2: the played symbol, registered.
- `busy` output 1: high while in PLAY.
- `done` output 1: one-cycle pulse at normal completion.
- `full` output 1: count == DEPTH.
- `count` output clog2(DEPTH)+1: number of stored entries.

## Operation
- Storage: DEPTH × (2+HOLD_W) register array; `count` doubles as the write pointer.
- Reset (`clr`=0): count=0, sym=0, busy=0, done=0, state=IDLE, internal index and hold counter =0. Array contents are don't-care.
- Write
  - Accepted only when IDLE, `wr_en`=1 and not full.
  - The entry goes to [count], then count increments.
  - Writes when full or busy are dropped; count does not change.
- Flush: when IDLE, sets count=0. Ignored when busy. If `flush` and `wr_en` arrive in the same cycle, flush wins.
- States:
  - IDLE
    - `start`=1 and count>0: go to PLAY, load idx=0, load the hold counter from entry 0, latch `loop`.
    - `start` with count=0: ignored, no `done` pulse.
  - PLAY
    - Drive sym=entry[idx].sym.
    - When the hold counter is nonzero, decrement it.
    - When the hold counter is 0 and idx<count-1: advance idx and reload the hold counter from the next entry.
    - When the hold counter is 0 and idx==count-1:
      - Loop latched: wrap to idx=0 and reload.
      - Not latched: go to IDLE and pulse `done`.
- `stop` in PLAY: go to IDLE next edge with no `done`. `stop` has priority over the end-of-list transition in the same cycle. `stop` in IDLE has no effect.
- `start` while in PLAY is ignored, including in the final cycle.
- `sym` keeps the last driven symbol in IDLE, after both completion and stop. It changes only in PLAY or on reset.
- Hold arithmetic:
  - The counter is HOLD_W bits and unsigned.
  - hold=0 gives one cycle; hold=2^HOLD_W−1 gives 2^HOLD_W cycles.
  - No saturation or overflow is possible.

## Timing
- Start latency: `start` sampled high at edge N → sym=entry0.sym and busy=1 from edge N+1 (first PLAY cycle).
- Each entry occupies exactly hold+1 consecutive PLAY cycles; no gap cycles between entries or across a loop wrap.
- Total one-shot length = Σ(hold_i+1) cycles. At the edge after the last cycle: busy→0, done=1 for that one cycle, state=IDLE.
- A new `start` is accepted in the same cycle `done` is high, because the state is already IDLE.
- `count`/`full` update at the edge after an accepted write or flush.
- Asynchronous reset mid-playback: all outputs go to their reset values immediately. No `done` pulse. Playback resumes only after a new `start`.

## Test plan
- Program (0,0),(1,1),(2,4),(0,0),(3,0), then start with loop=0 → sym over 10 cycles = 0,1,1,2,2,2,2,2,0,3; busy high for exactly those 10 cycles; done pulses once in cycle 11; sym stays 3 afterwards.
- Same list with loop=1, run 25 cycles → the pattern repeats with period 10 and no bubble at the wrap; `stop` at cycle 13 → busy=0 next edge, no done, sym holds 1.
- Write 9 entries with DEPTH=8 → count=8, full=1, 9th write dropped; flush → count=0, full=0; start with count=0 → busy stays 0, no done.
- Single entry (2,15) → sym=2 for exactly 16 cycles, then done; wr_en/flush/start during playback → no effect on count or sequence.
- Assert clr=0 asynchronously between clock edges mid-playback → sym=0, busy=0, count=0 without waiting for a clock edge; after release, start alone is ignored until new entries are written.
- stop and end-of-list in the same cycle → IDLE, done=0; start in the done cycle → replay begins the next edge.
